// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side blocks.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } uart_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so `ptr` sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic          found;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      assign rot[gi] = req[IW'((gi + int'(ptr)) % N)];
    end
  endgenerate

  always_comb begin
    off   = '0;
    found = 1'b0;
    // Descending scan so the lowest rotated position wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = IW'(i);
        found = 1'b1;
      end
    end
    idx   = IW'((int'(off) + int'(ptr)) % N);
    grant = '0;
    if (found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte streams; the grant stays
// locked to one requester until its frame ends or it stalls too long.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*UART_BYTE_W-1:0] req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]       tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [$clog2(N_REQ)-1:0]     owner,
  output logic                         owner_valid,
  output logic                         timeout_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(LOCK_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [IW-1:0] PTR_TOP    = IW'(N_REQ - 1);

  uart_arb_state_t        state_reg, state_next;
  logic [IW-1:0]          owner_reg, owner_next;
  logic [IW-1:0]          last_owner_reg, last_owner_next;
  logic [UART_BYTE_W-1:0] data_reg, data_next;
  logic                   last_reg, last_next;
  logic [TW-1:0]          timer_reg, timer_next;
  logic                   timeout_reg, timeout_next;

  logic [IW-1:0]          rr_ptr, win_idx, sel_idx;
  logic [N_REQ-1:0]       win_grant, ready_c;
  logic [UART_BYTE_W-1:0] lane_data [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign lane_data[gi] = req_data[gi*UART_BYTE_W +: UART_BYTE_W];
    end
  endgenerate

  assign rr_ptr = (last_owner_reg == PTR_TOP) ? '0 : last_owner_reg + 1'b1;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx)
  );

  // While locked only the owner's lane can be captured.
  assign sel_idx = (state_reg == HOLD) ? owner_reg : win_idx;

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    data_next       = data_reg;
    last_next       = last_reg;
    timer_next      = timer_reg;
    timeout_next    = 1'b0;
    ready_c         = '0;

    case (state_reg)
      IDLE: begin
        ready_c = win_grant;
        if (|req_valid) begin
          owner_next = win_idx;
          data_next  = lane_data[sel_idx];
          last_next  = req_last[sel_idx];
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (tx_ready) begin
          if (last_reg) begin
            last_owner_next = owner_reg;
            state_next      = IDLE;
          end else begin
            timer_next = '0;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        ready_c[owner_reg] = req_valid[owner_reg];
        if (req_valid[owner_reg]) begin
          data_next  = lane_data[sel_idx];
          last_next  = req_last[sel_idx];
          timer_next = '0;
          state_next = ISSUE;
        end else if (timer_reg == TIMER_LAST) begin
          last_owner_next = owner_reg;
          timeout_next    = 1'b1;
          state_next      = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_owner_reg <= PTR_TOP;
      data_reg       <= '0;
      last_reg       <= 1'b0;
      timer_reg      <= '0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      data_reg       <= data_next;
      last_reg       <= last_next;
      timer_reg      <= timer_next;
      timeout_reg    <= timeout_next;
    end
  end

  // Accept strobes are combinational, so hold them low while reset is asserted.
  assign req_ready   = rst_n ? ready_c : '0;
  assign tx_valid    = (state_reg == ISSUE);
  assign tx_data     = data_reg;
  assign owner       = owner_reg;
  assign owner_valid = (state_reg != IDLE);
  assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized frames,
// all checked every cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int LT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [1:0]  owner;
  logic        owner_valid;
  logic        timeout_err;

  uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(LT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .owner       (owner),
    .owner_valid (owner_valid),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       busy;      // a byte is waiting for the transmitter
    logic       locked;    // a grant is held (frame in progress)
    logic [7:0] byt;
    logic       lst;
    int         own;
    int         last_own;
    int         idle;      // cycles the owner has left the lane empty
    logic       tmo;
  } mdl_t;

  mdl_t m;

  function automatic int pick(input logic [3:0] v, input int lo);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (lo + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r = '0;
    r.last_own = N - 1;
    return r;
  endfunction

  function automatic mdl_t step(input mdl_t s, input logic [3:0] v, input logic [31:0] d,
                                input logic [3:0] l, input logic tr);
    mdl_t n;
    int w;
    n = s;
    n.tmo = 1'b0;
    if (s.busy) begin
      if (tr) begin
        n.busy = 1'b0;
        if (s.lst) begin
          n.locked = 1'b0;
          n.last_own = s.own;
        end else n.idle = 0;
      end
    end else if (s.locked) begin
      if (v[s.own]) begin
        n.busy = 1'b1;
        n.byt = d[s.own*8 +: 8];
        n.lst = l[s.own];
        n.idle = 0;
      end else if (s.idle == LT - 1) begin
        n.locked = 1'b0;
        n.last_own = s.own;
        n.tmo = 1'b1;
      end else n.idle = s.idle + 1;
    end else begin
      w = pick(v, s.last_own);
      if (w >= 0) begin
        n.busy = 1'b1;
        n.locked = 1'b1;
        n.own = w;
        n.byt = d[w*8 +: 8];
        n.lst = l[w];
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] exp_ready(input mdl_t s, input logic [3:0] v);
    logic [3:0] r;
    int w;
    r = '0;
    if (!s.busy) begin
      if (s.locked) r[s.own] = v[s.own];
      else begin
        w = pick(v, s.last_own);
        if (w >= 0) r[w] = 1'b1;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= mdl_reset();
    else        m <= step(m, req_valid, req_data, req_last, tx_ready);
  end

  // ---------------- per-lane byte sources ----------------
  logic [8:0] lane_mem [4][64];
  int         head [4];
  int         tail [4];
  logic [3:0] acc_s = '0;
  bit         rnd_mode = 1'b0;
  int         acc_q[$];
  logic [7:0] txq[$];

  task automatic push(input int lane, input logic [7:0] b, input logic l);
    lane_mem[lane][tail[lane] % 64] = {l, b};
    tail[lane]++;
  endtask

  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_s[i] && head[i] != tail[i]) begin
        head[i]++;
        req_valid[i] = 1'b0;
      end
      if (!req_valid[i] && head[i] != tail[i] && (!rnd_mode || $urandom_range(0, 1) == 1)) begin
        req_valid[i] = 1'b1;
        {req_last[i], req_data[i*8 +: 8]} = lane_mem[i][head[i] % 64];
      end
      if (!req_valid[i]) begin
        req_data[i*8 +: 8] = 8'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("req_ready", 32'(req_ready), 32'(exp_ready(m, req_valid)));
      check("tx_valid", 32'(tx_valid), 32'(m.busy));
      check("tx_data", 32'(tx_data), 32'(m.byt));
      check("owner", 32'(owner), 32'(m.own));
      check("owner_valid", 32'(owner_valid), 32'(m.locked));
      check("timeout_err", 32'(timeout_err), 32'(m.tmo));
      acc_s = req_valid & req_ready;
      for (int i = 0; i < N; i++) if (acc_s[i]) acc_q.push_back(i);
      if (tx_valid && tx_ready) begin
        txq.push_back(tx_data);
        $display("tx byte=%02h from req%0d at cycle %0d", tx_data, owner, cyc);
      end
    end else begin
      acc_s = '0;
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) head[i] = tail[i];
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int fair_exp [6] = '{0, 1, 2, 3, 0, 1};
  logic [7:0] lock_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h99};
  int hold_cyc, tmo_cyc, tmo_cnt;

  initial begin
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_owner_valid", 32'(owner_valid), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    tick();
    rst_n = 1'b1;

    // Single byte
    push(1, 8'hA5, 1'b1);
    tick();
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'h2);
    tick();
    @(negedge clk);
    check("single_tx_valid", 32'(tx_valid), 1);
    check("single_tx_data", 32'(tx_data), 32'hA5);
    check("single_owner", 32'(owner), 1);
    check("single_issue_ready", 32'(req_ready), 0);
    tick();
    @(negedge clk);
    check("single_owner_valid", 32'(owner_valid), 0);

    // Fairness
    do_reset();
    acc_q.delete();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) push(i, 8'(16 * i + k), 1'b1);
    repeat (16) tick();
    check("fair_count", 32'(acc_q.size() >= 6), 1);
    for (int i = 0; i < 6 && i < acc_q.size(); i++) check("fair_order", 32'(acc_q[i]), 32'(fair_exp[i]));

    // Frame lock
    do_reset();
    txq.delete();
    push(2, 8'h11, 1'b0);
    push(2, 8'h22, 1'b0);
    push(2, 8'h33, 1'b1);
    tick();
    tick();
    push(0, 8'h99, 1'b1);
    repeat (14) tick();
    check("lock_count", 32'(txq.size() >= 4), 1);
    for (int i = 0; i < 4 && i < txq.size(); i++) check("lock_order", 32'(txq[i]), 32'(lock_exp[i]));

    // Backpressure
    do_reset();
    tx_ready = 1'b0;
    push(0, 8'h5C, 1'b1);
    push(1, 8'h66, 1'b1);
    tick();
    tick();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("bp_tx_valid", 32'(tx_valid), 1);
      check("bp_tx_data", 32'(tx_data), 32'h5C);
      check("bp_req_ready", 32'(req_ready), 0);
      tick();
    end
    tx_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", 32'(tx_valid), 1);
    tick();
    @(negedge clk);
    check("bp_after_hs", 32'(tx_valid), 0);

    // Timeout
    do_reset();
    push(3, 8'h77, 1'b0);
    tick();
    tick();
    push(0, 8'h99, 1'b1);
    hold_cyc = -1;
    tmo_cyc = -1;
    for (int k = 0; k < 40 && tmo_cyc < 0; k++) begin
      @(negedge clk);
      if (hold_cyc < 0 && owner_valid && !tx_valid) hold_cyc = cyc;
      if (timeout_err) begin
        tmo_cyc = cyc;
        check("tmo_ready", 32'(req_ready), 32'h1);
        check("tmo_owner_valid", 32'(owner_valid), 0);
      end
    end
    check("tmo_seen", 32'(tmo_cyc >= 0), 1);
    check("tmo_delay", 32'(tmo_cyc - hold_cyc), 16);
    tick();

    // Owner returns on the last allowed HOLD cycle
    do_reset();
    txq.delete();
    push(3, 8'h77, 1'b0);
    tick();
    tick();
    tick();
    repeat (14) tick();
    push(3, 8'h88, 1'b1);
    tmo_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (timeout_err) tmo_cnt++;
    end
    check("late_no_timeout", 32'(tmo_cnt), 0);
    check("late_tx_count", 32'(txq.size()), 2);
    if (txq.size() >= 2) check("late_tx_byte", 32'(txq[1]), 32'h88);

    // Reset mid-frame
    do_reset();
    tx_ready = 1'b0;
    push(1, 8'h42, 1'b1);
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("async_tx_valid", 32'(tx_valid), 0);
    check("async_tx_data", 32'(tx_data), 0);
    check("async_owner_valid", 32'(owner_valid), 0);
    check("async_req_ready", 32'(req_ready), 0);
    push(0, 8'h10, 1'b1);
    push(3, 8'h30, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    check("rst_rr_ready", 32'(req_ready), 32'h1);
    tick();
    @(negedge clk);
    check("rst_rr_data", 32'(tx_data), 32'h10);
    check("rst_rr_owner", 32'(owner), 0);

    // Randomized traffic, including truncated frames that must time out
    do_reset();
    rnd_mode = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) begin
        int lane, len;
        lane = $urandom_range(0, N - 1);
        len = $urandom_range(1, 4);
        if (tail[lane] - head[lane] < 40) begin
          for (int b = 0; b < len; b++)
            push(lane, 8'($urandom), (b == len - 1) && ($urandom_range(0, 99) < 85));
        end
      end
      tick();
    end
    rnd_mode = 1'b0;
    tx_ready = 1'b1;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter between `N_REQ` byte-stream requesters. A round-robin arbiter picks a requester. The winner's bytes are sent to the transmitter's byte input over a valid/ready handshake. The grant stays locked to that requester until it marks the last byte of its frame, so frames from different requesters never interleave. The block sits between the software/peripheral byte sources and the UART transmitter core.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `LOCK_TIMEOUT`, 1024: idle cycles a locked owner may stall before its lock is released, ≥2.
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input N_REQ: requester i has a byte on its lane.
- `req_data` input N_REQ*8: byte lanes; lane i is bits [8i+7:8i].
- `req_last` input N_REQ: byte on lane i ends its frame.
- `req_ready` output N_REQ: one-hot accept. The byte on lane i transfers at the edge where `req_valid[i] && req_ready[i]`.
- `tx_data` output 8: byte to the transmitter.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: transmitter can accept a byte.
- `owner` output $clog2(N_REQ): current or last granted requester.
- `owner_valid` output 1: a grant is active (state ISSUE or HOLD).
- `timeout_err` output 1: one-cycle pulse when a lock is released by timeout.

## Operation
- States: IDLE, ISSUE, HOLD.
- **IDLE**
  - If any `req_valid` is high, `req_ready` is driven combinationally high for the round-robin winner only. Search starts at `last_owner+1` mod N_REQ.
  - On that edge: capture the data and last bit, set `owner` = winner, go to ISSUE.
- **ISSUE**
  - `tx_valid`=1; `tx_data` holds the captured byte.
  - Wait for the edge with `tx_ready`=1.
  - On that edge: if the captured last bit is 1, set `last_owner` = `owner` and go to IDLE. Otherwise clear the timer and go to HOLD.
  - `req_ready` is all-zero in ISSUE.
- **HOLD**
  - Only `owner` is eligible; `req_ready[owner]` = `req_valid[owner]`.
  - On accept: capture the byte, clear the timer, go to ISSUE.
  - Otherwise the timer increments. With timer == LOCK_TIMEOUT-1 and no owner valid: set `last_owner` = `owner` and go to IDLE.
  - Other requesters are ignored for the whole time the lock is held.
- Round-robin pointer `last_owner` resets to N_REQ-1, so requester 0 has first priority after reset.
- `tx_valid` never drops and `tx_data` never changes before the handshake.
- `req_valid`/`req_data` of a requester are ignored after its byte is accepted.
- Timer width is $clog2(LOCK_TIMEOUT); the timer saturates and never wraps.

## Timing
- Reset values:
  - state IDLE; `tx_valid` 0; `tx_data` 0x00; `owner` 0; `owner_valid` 0; `timeout_err` 0.
  - `req_ready` all 0; timer 0; `last_owner` N_REQ-1.
- Accept at edge t (`req_ready` high in cycle t-1) → `tx_valid`=1 in cycle t.
- Minimum period is 2 cycles per byte (accept cycle plus ISSUE cycle) with `tx_ready` held high.
- Within a frame, the next byte can be accepted the first cycle after the ISSUE handshake (HOLD cycle).
- Timeout: if HOLD is first occupied in cycle h and the owner never asserts valid, then `timeout_err`=1 in cycle h+LOCK_TIMEOUT only, with state IDLE in that cycle.
  - Arbitration in that IDLE cycle proceeds normally and can grant in the same cycle.
  - If owner valid arrives in cycle h+LOCK_TIMEOUT-1, it is accepted and no timeout occurs.
- Reset mid-operation, asynchronous:
  - All outputs return to their reset values immediately. A byte not yet handshaken is dropped.
  - After release, arbitration restarts with requester 0 highest.
- `tx_ready` high outside ISSUE has no effect.

## Structure
- Shared package `uart_pkg` holds:
  - `uart_arb_state_t` enum (IDLE, ISSUE, HOLD).
  - `UART_BYTE_W`=8.
- Sub-module `rr_arbiter`: combinational rotate–priority-encode–unrotate.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and index.
  - Parameter: N.
- The top level contains the FSM, capture registers, timer and pointer.

## Test plan
- **Single byte:** after reset, req1 sends 0xA5 with last=1 and `tx_ready`=1.
  - `req_ready`=0010 for one cycle.
  - Next cycle: `tx_valid`=1, `tx_data`=0xA5, `owner`=1.
  - Following cycle: IDLE, `owner_valid`=0.
- **Fairness:** all four requesters continuously valid with last=1 → grant order 0,1,2,3,0,1; each byte takes 2 cycles.
- **Frame lock:** req2 sends 0x11, 0x22, 0x33 (last on 0x33) while req0 is valid throughout.
  - `tx_data` sequence is 0x11, 0x22, 0x33, then req0's byte.
  - `req_ready[0]`=0 until the lock releases.
- **Backpressure:** `tx_ready`=0 for 50 cycles in ISSUE with 0x5C.
  - `tx_valid`=1 and `tx_data`=0x5C stable for all 50 cycles; `req_ready`=0.
  - Handshake on the cycle `tx_ready` rises.
- **Timeout (LOCK_TIMEOUT=16):** req3 sends 0x77 with last=0, then drops valid.
  - `timeout_err` pulses exactly 16 cycles after HOLD entry.
  - req0, valid meanwhile, is granted in that same cycle.
- **Reset mid-frame:** assert `rst_n` low during ISSUE.
  - `tx_valid`=0 asynchronously.
  - After release, with req0 and req3 both valid, req0 wins.
